dm_unit: RTL and testbench



---
 rtl/dm_unit.sv | 123 ++++++++++++
 tb/tb_dm_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_unit.sv
// Data-memory stage: byte/half/word loads and stores on a word-organised RAM, load result sign/zero extended.
// Latency: stores commit at the request edge; load data and dout_valid appear one cycle after the request.
// Backpressure: none; one access per cycle, misaligned or illegal-type requests are dropped and flagged.
module dm_unit #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_en,
   input  logic        DMWr,
   input  logic [2:0]  DMType,
   input  logic [31:0] addr,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        dout_valid,
   output logic        misalign
);

   localparam logic [2:0] T_W  = 3'd0;
   localparam logic [2:0] T_H  = 3'd1;
   localparam logic [2:0] T_HU = 3'd2;
   localparam logic [2:0] T_B  = 3'd3;
   localparam logic [2:0] T_BU = 3'd4;

   logic [31:0]   mem [DEPTH_WORDS];

   logic [AW-1:0] idx;
   logic [1:0]    off;
   logic          addr_unused;
   logic          type_ok;
   logic          aligned;
   logic          accept;
   logic          wr_en;
   logic [3:0]    be;
   logic [31:0]   wdat;

   // the load word is captured into its own resettable register so dout clears on reset
   logic [31:0]   rd_word;
   logic [1:0]    off_q;
   logic [2:0]    type_q;
   logic [15:0]   half_sel;
   logic [7:0]    byte_sel;

   assign idx         = addr[AW+1:2];
   assign off         = addr[1:0];
   // upper address bits are deliberately ignored so the RAM aliases modulo its size
   assign addr_unused = ^addr[31:AW+2];

   // decode type legality, alignment, lane enables and replicated write data
   always_comb begin
      type_ok = (DMType <= T_BU);
      aligned = 1'b1;
      be      = 4'b0000;
      wdat    = din;
      case (DMType)
         T_W: begin
            aligned = (off == 2'b00);
            be      = 4'b1111;
            wdat    = din;
         end
         T_H, T_HU: begin
            aligned = ~off[0];
            be      = off[1] ? 4'b1100 : 4'b0011;
            wdat    = {2{din[15:0]}};
         end
         T_B, T_BU: begin
            aligned = 1'b1;
            be      = 4'b0001 << off;
            wdat    = {4{din[7:0]}};
         end
         default: begin
            aligned = 1'b1;
            be      = 4'b0000;
            wdat    = din;
         end
      endcase
      accept = mem_en & type_ok & aligned;
      wr_en  = accept & DMWr & ~rst;
   end

   // byte-lane RAM write; contents are intentionally not reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_en && be[i]) begin
            mem[idx][8*i +: 8] <= wdat[8*i +: 8];
         end
      end
   end

   // load capture and status pulses; reset drops any load in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_word    <= 32'd0;
         off_q      <= 2'd0;
         type_q     <= 3'd0;
         dout_valid <= 1'b0;
         misalign   <= 1'b0;
      end else begin
         dout_valid <= accept & ~DMWr;
         misalign   <= mem_en & ~(type_ok & aligned);
         if (accept && !DMWr) begin
            rd_word <= mem[idx];
            off_q   <= off;
            type_q  <= DMType;
         end
      end
   end

   // extract and extend from the registered word; holds while rd_word holds
   always_comb begin
      half_sel = off_q[1] ? rd_word[31:16] : rd_word[15:0];
      byte_sel = rd_word[8*off_q +: 8];
      case (type_q)
         T_H:     dout = {{16{half_sel[15]}}, half_sel};
         T_HU:    dout = {16'd0, half_sel};
         T_B:     dout = {{24{byte_sel[7]}}, byte_sel};
         T_BU:    dout = {24'd0, byte_sel};
         default: dout = rd_word;
      endcase
   end

endmodule

// File: tb/tb_dm_unit.sv
// Testbench for dm_unit: directed scenarios plus randomized traffic against a byte-array model.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: none; one request driven per cycle.
module tb_dm_unit;

   localparam int DEPTH = 1024;
   localparam int unsigned SPAN = 4 * DEPTH;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_en;
   logic        DMWr;
   logic [2:0]  DMType;
   logic [31:0] addr;
   logic [31:0] din;
   logic [31:0] dout;
   logic        dout_valid;
   logic        misalign;

   int total = 0;
   int bad   = 0;

   // behavioural model: byte-addressed memory plus expected output state
   logic [7:0]  mb [int unsigned];
   logic [31:0] exp_dout = 0;
   logic        exp_vld  = 0;
   logic        exp_mis  = 0;

   dm_unit #(.DEPTH_WORDS(DEPTH), .AW(10)) dut (
      .clk(clk), .rst(rst), .mem_en(mem_en), .DMWr(DMWr), .DMType(DMType),
      .addr(addr), .din(din), .dout(dout), .dout_valid(dout_valid), .misalign(misalign)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rdb(input int unsigned a);
      if (mb.exists(a)) return mb[a];
      return 8'h00;
   endfunction

   function automatic bit legal(input logic [2:0] t, input int unsigned ma);
      if (t > 3'd4) return 1'b0;
      if (t == 3'd0) return (ma % 4) == 0;
      if (t <= 3'd2) return (ma % 2) == 0;
      return 1'b1;
   endfunction

   function automatic logic [31:0] mload(input logic [2:0] t, input int unsigned ma);
      int unsigned wb = ma - (ma % 4);
      int          h;
      int          b;
      h = int'(rdb(ma + 1)) * 256 + int'(rdb(ma));
      b = int'(rdb(ma));
      case (t)
         3'd0: return {rdb(wb + 3), rdb(wb + 2), rdb(wb + 1), rdb(wb)};
         3'd1: return (h >= 32768) ? 32'(h - 65536) : 32'(h);
         3'd2: return 32'(h);
         3'd3: return (b >= 128) ? 32'(b - 256) : 32'(b);
         default: return 32'(b);
      endcase
   endfunction

   task automatic model(input bit r, input bit en, input bit wr, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] d);
      int unsigned ma = a % SPAN;
      if (r) begin
         exp_dout = 0; exp_vld = 0; exp_mis = 0;
      end else if (!en) begin
         exp_vld = 0; exp_mis = 0;
      end else if (!legal(t, ma)) begin
         exp_vld = 0; exp_mis = 1;
      end else if (wr) begin
         exp_vld = 0; exp_mis = 0;
         if (t == 3'd0) begin
            for (int i = 0; i < 4; i++) mb[ma + i] = d[8*i +: 8];
         end else if (t <= 3'd2) begin
            mb[ma] = d[7:0]; mb[ma + 1] = d[15:8];
         end else begin
            mb[ma] = d[7:0];
         end
      end else begin
         exp_vld = 1; exp_mis = 0; exp_dout = mload(t, ma);
      end
   endtask

   // drive one request across one rising edge, then advance the model
   task automatic step(input bit r, input bit en, input bit wr, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] d);
      rst = r; mem_en = en; DMWr = wr; DMType = t; addr = a; din = d;
      @(posedge clk);
      #1;
      model(r, en, wr, t, a, d);
   endtask

   task automatic test_reset();
      step(1, 1, 1, 3'd0, 32'h0, 32'hCAFEF00D);
      step(1, 1, 1, 3'd0, 32'h0, 32'hCAFEF00D);
      total++;
      if ({dout_valid, misalign, dout} !== {1'b0, 1'b0, 32'h0}) begin
         bad++;
         $display("FAIL reset_out: got vld=%0b mis=%0b dout=%h want 0 0 00000000", dout_valid, misalign, dout);
      end
      step(0, 1, 0, 3'd0, 32'h0, 32'h0);
      total++;
      if (dout_valid !== 1'b1 || dout === 32'hCAFEF00D) begin
         bad++;
         $display("FAIL reset_store_dropped: got vld=%0b dout=%h want vld=1 dout!=cafef00d", dout_valid, dout);
      end
      step(1, 0, 0, 3'd0, 32'h0, 32'h0);
      step(0, 0, 0, 3'd0, 32'h0, 32'h0);
   endtask

   task automatic test_word();
      step(0, 1, 1, 3'd0, 32'h10, 32'hDEADBEEF);
      total++;
      if ({dout_valid, misalign} !== 2'b00) begin
         bad++;
         $display("FAIL sw_status: got vld=%0b mis=%0b want 0 0", dout_valid, misalign);
      end
      step(0, 1, 0, 3'd0, 32'h10, 32'h0);
      total++;
      if ({dout_valid, misalign, dout} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
         bad++;
         $display("FAIL lw_roundtrip: got vld=%0b mis=%0b dout=%h want 1 0 deadbeef", dout_valid, misalign, dout);
      end
      step(0, 0, 0, 3'd0, 32'h0, 32'h0);
      total++;
      if ({dout_valid, misalign, dout} !== {1'b0, 1'b0, 32'hDEADBEEF}) begin
         bad++;
         $display("FAIL idle_hold: got vld=%0b mis=%0b dout=%h want 0 0 deadbeef", dout_valid, misalign, dout);
      end
   endtask

   task automatic test_subword();
      logic [2:0]  lt [5]  = '{3'd0, 3'd3, 3'd4, 3'd1, 3'd2};
      logic [31:0] la [5]  = '{32'h20, 32'h21, 32'h21, 32'h22, 32'h22};
      logic [31:0] lx [5]  = '{32'hF00F8000, 32'hFFFFFF80, 32'h00000080, 32'hFFFFF00F, 32'h0000F00F};
      step(0, 1, 1, 3'd0, 32'h20, 32'h0);
      step(0, 1, 1, 3'd3, 32'h21, 32'h12345680);
      step(0, 1, 1, 3'd1, 32'h22, 32'h9876F00F);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, lt[i], la[i], 32'h0);
         total++;
         if ({dout_valid, dout} !== {1'b1, lx[i]}) begin
            bad++;
            $display("FAIL subword_load%0d: got vld=%0b dout=%h want 1 %h", i, dout_valid, dout, lx[i]);
         end
      end
   endtask

   task automatic test_misalign();
      step(0, 1, 1, 3'd0, 32'h30, 32'h11111111);
      step(0, 1, 1, 3'd0, 32'h31, 32'h22222222);
      total++;
      if ({dout_valid, misalign} !== 2'b01) begin
         bad++;
         $display("FAIL misalign_sw: got vld=%0b mis=%0b want 0 1", dout_valid, misalign);
      end
      step(0, 1, 0, 3'd1, 32'h33, 32'h0);
      total++;
      if ({dout_valid, misalign, dout} !== {1'b0, 1'b1, exp_dout}) begin
         bad++;
         $display("FAIL misalign_lh: got vld=%0b mis=%0b dout=%h want 0 1 %h", dout_valid, misalign, dout, exp_dout);
      end
      step(0, 1, 0, 3'd0, 32'h30, 32'h0);
      total++;
      if ({dout_valid, misalign, dout} !== {1'b1, 1'b0, 32'h11111111}) begin
         bad++;
         $display("FAIL misalign_nowrite: got vld=%0b mis=%0b dout=%h want 1 0 11111111", dout_valid, misalign, dout);
      end
   endtask

   task automatic test_wrap_illegal();
      step(0, 1, 1, 3'd0, SPAN + 32'h8, 32'hA5A5A5A5);
      step(0, 1, 0, 3'd0, 32'h8, 32'h0);
      total++;
      if ({dout_valid, dout} !== {1'b1, 32'hA5A5A5A5}) begin
         bad++;
         $display("FAIL wrap_lw: got vld=%0b dout=%h want 1 a5a5a5a5", dout_valid, dout);
      end
      step(0, 1, 1, 3'd7, 32'h8, 32'hFFFFFFFF);
      total++;
      if ({dout_valid, misalign} !== 2'b01) begin
         bad++;
         $display("FAIL illegal_type: got vld=%0b mis=%0b want 0 1", dout_valid, misalign);
      end
      step(0, 1, 0, 3'd0, 32'h8, 32'h0);
      total++;
      if (dout !== 32'hA5A5A5A5) begin
         bad++;
         $display("FAIL illegal_nowrite: got dout=%h want a5a5a5a5", dout);
      end
   endtask

   task automatic test_reset_midload();
      step(0, 1, 1, 3'd0, 32'h40, 32'h5A5A1234);
      step(0, 1, 0, 3'd0, 32'h40, 32'h0);
      step(1, 0, 0, 3'd0, 32'h0, 32'h0);
      total++;
      if ({dout_valid, misalign, dout} !== {1'b0, 1'b0, 32'h0}) begin
         bad++;
         $display("FAIL reset_midload: got vld=%0b mis=%0b dout=%h want 0 0 00000000", dout_valid, misalign, dout);
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [2:0]  t;
      bit          r, en, wr;
      for (int w = 0; w < 16; w++) step(0, 1, 1, 3'd0, 32'h100 + 32'(4 * w), $urandom);
      for (int n = 0; n < 400; n++) begin
         r  = ($urandom_range(0, 49) == 0);
         en = ($urandom_range(0, 7) != 0);
         wr = $urandom_range(0, 1);
         t  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         a  = 32'h100 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 7)) << 12);
         step(r, en, wr, t, a, $urandom);
         total++;
         if ({dout_valid, misalign, dout} !== {exp_vld, exp_mis, exp_dout}) begin
            bad++;
            $display("FAIL random%0d: got vld=%0b mis=%0b dout=%h want %0b %0b %h",
                     n, dout_valid, misalign, dout, exp_vld, exp_mis, exp_dout);
         end
      end
   endtask

   initial begin
      rst = 1; mem_en = 0; DMWr = 0; DMType = 0; addr = 0; din = 0;
      test_reset();
      test_word();
      test_subword();
      test_misalign();
      test_wrap_illegal();
      test_reset_midload();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
